// File: rtl/dm_pkg.sv
// Shared encodings for the multi-cycle data-memory responder: access sizes, FSM states and the
// wait-state counter width.
package dm_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Wide enough for WAIT_CYCLES up to 15
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } dm_state_e;

endpackage

// File: rtl/dm_lane_align.sv
// Combinational little-endian lane steering: store merge mask/data and load extract/extend.
// Also used by the ME-stage forwarding path.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sign,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] wmask,
  output logic [31:0] wshift,
  output logic [31:0] rext
);

  logic [15:0] half;
  logic [7:0]  byte_v;

  always_comb begin
    wmask  = 32'hFFFF_FFFF;
    wshift = wdata;
    rext   = rword;
    half   = 16'h0;
    byte_v = 8'h0;
    case (size)
      SZ_HALF: begin
        if (lane[1]) begin
          wmask  = 32'hFFFF_0000;
          wshift = {wdata[15:0], 16'h0};
          half   = rword[31:16];
        end else begin
          wmask  = 32'h0000_FFFF;
          wshift = {16'h0, wdata[15:0]};
          half   = rword[15:0];
        end
        rext = sign ? {{16{half[15]}}, half} : {16'h0, half};
      end
      SZ_BYTE: begin
        unique case (lane)
          2'd0: begin wmask = 32'h0000_00FF; wshift = {24'h0, wdata[7:0]};        byte_v = rword[7:0];   end
          2'd1: begin wmask = 32'h0000_FF00; wshift = {16'h0, wdata[7:0], 8'h0};  byte_v = rword[15:8];  end
          2'd2: begin wmask = 32'h00FF_0000; wshift = {8'h0, wdata[7:0], 16'h0};  byte_v = rword[23:16]; end
          2'd3: begin wmask = 32'hFF00_0000; wshift = {wdata[7:0], 24'h0};        byte_v = rword[31:24]; end
          default: ;
        endcase
        rext = sign ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
      end
      // Word and reserved size both access the full word, ignoring the lane bits
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory target with req/ack handshake and sub-word load/store support.
// Define DM_MISALIGN_TRAP_EN to add the err port and suppress misaligned accesses.
module data_mem_responder
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic        busy,
  output logic        ack,
  output logic [31:0] rdata
`ifdef DM_MISALIGN_TRAP_EN
  ,
  output logic        err
`endif
);

  dm_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, sign_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]      wdata_q, rdata_q;
  logic [1:0]       size_q;
  logic [31:0]      mem [DEPTH_WORDS];

  logic             accept, commit, do_write, do_read, mis;
  logic             a_we, a_sign;
  logic [ADDR_W+1:0] a_addr;
  logic [31:0]      a_wdata, rword, wmask, wshift, rext;
  logic [1:0]       a_size;
  logic             unused_addr;

  assign unused_addr = ^addr[31:ADDR_W+2];

  assign accept = rst_n && (state_q == StIdle) && req;
  assign commit = (accept && (WAIT_CYCLES == 0)) ||
                  ((state_q == StWait) && (cnt_q == CNT_W'(1)));

  // With zero wait states the access commits on the accept edge, so use the live inputs there
  assign a_we    = (state_q == StIdle) ? we    : we_q;
  assign a_sign  = (state_q == StIdle) ? sign  : sign_q;
  assign a_addr  = (state_q == StIdle) ? addr[ADDR_W+1:0] : addr_q;
  assign a_wdata = (state_q == StIdle) ? wdata : wdata_q;
  assign a_size  = (state_q == StIdle) ? size  : size_q;

`ifdef DM_MISALIGN_TRAP_EN
  assign mis = ((a_size == SZ_WORD) && (a_addr[1:0] != 2'b00)) ||
               ((a_size == SZ_HALF) && a_addr[0]) ||
               (a_size == SZ_RSVD);
`else
  assign mis = 1'b0;
`endif

  assign do_write = commit && a_we && !mis;
  assign do_read  = commit && !a_we && !mis;
  assign rword    = mem[a_addr[ADDR_W+1:2]];

  dm_lane_align u_align (
    .size   (a_size),
    .lane   (a_addr[1:0]),
    .sign   (a_sign),
    .wdata  (a_wdata),
    .rword  (rword),
    .wmask  (wmask),
    .wshift (wshift),
    .rext   (rext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SZ_WORD;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= we;
        sign_q  <= sign;
        addr_q  <= addr[ADDR_W+1:0];
        wdata_q <= wdata;
        size_q  <= size;
      end
      if (do_read) rdata_q <= rext;
    end
  end

  // Storage is deliberately left uncleared by reset
  always_ff @(posedge clk) begin
    if (do_write) mem[a_addr[ADDR_W+1:2]] <= (rword & ~wmask) | (wshift & wmask);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? StResp : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy  = (state_q != StIdle);
    ack   = (state_q == StResp);
    rdata = rdata_q;
`ifdef DM_MISALIGN_TRAP_EN
    err   = (state_q == StResp) && mis;
`endif
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed scoreboard bench for data_mem_responder: one WAIT_CYCLES=2 and one WAIT_CYCLES=0 instance.
module tb_data_mem_responder;

  localparam logic [1:0] W = 2'b00, H = 2'b01, B = 2'b10;

  typedef struct {
    logic [31:0] rd;
    logic        er;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0, sign = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [1:0]  size = 2'b00;
  logic        busy2, ack2, busy0, ack0;
  logic [31:0] rdata2, rdata0;
`ifdef DM_MISALIGN_TRAP_EN
  logic        err2, err0;
`endif

  int   n_pass = 0;
  int   n_total = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(1024), .ADDR_W(10), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .size(size), .sign(sign), .busy(busy2), .ack(ack2), .rdata(rdata2)
`ifdef DM_MISALIGN_TRAP_EN
    , .err(err2)
`endif
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .size(size), .sign(sign), .busy(busy0), .ack(ack0), .rdata(rdata0)
`ifdef DM_MISALIGN_TRAP_EN
    , .err(err0)
`endif
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // One access on the WAIT_CYCLES=2 instance; inputs are scrambled while it is busy
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] s, input logic sg, input logic [31:0] exp_rd,
                        input logic exp_er);
    int   cyc;
    exp_t e;
    exp_t pe;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; size = s; sign = sg;
    pe.rd = exp_rd;
    pe.er = exp_er;
    sb_q.push_back(pe);
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; we = ~w; addr = $urandom; wdata = $urandom;
    size = 2'($urandom_range(0, 3)); sign = ~sg;
    check1("busy_after_accept", busy2, 1'b1);
    cyc = 0;
    while (!ack2 && cyc < 16) begin
      @(negedge clk);
      cyc++;
    end
    check1("ack_seen", ack2, 1'b1);
    check32("ack_latency", 32'(cyc), 32'd2);
    e = sb_q.pop_front();
    check32("rdata", rdata2, e.rd);
    check1("busy_at_ack", busy2, 1'b1);
`ifdef DM_MISALIGN_TRAP_EN
    check1("err_at_ack", err2, e.er);
`endif
    @(negedge clk);
    check1("ack_one_cycle", ack2, 1'b0);
    check1("busy_released", busy2, 1'b0);
`ifdef DM_MISALIGN_TRAP_EN
    check1("err_cleared", err2, 1'b0);
`endif
  endtask

  initial begin
    int  n_ack;
    logic prev_ack;
    logic saw_ack;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check1("rst_busy", busy2, 1'b0);
    check1("rst_ack", ack2, 1'b0);
    check32("rst_rdata", rdata2, 32'h0);
    check32("rst_rdata_w0", rdata0, 32'h0);
`ifdef DM_MISALIGN_TRAP_EN
    check1("rst_err", err2, 1'b0);
`endif
    rst_n = 1'b1;

    access(1'b1, 32'h10, 32'hDEADBEEF, W, 1'b0, 32'h0, 1'b0);
    access(1'b0, 32'h10, 32'h0, W, 1'b0, 32'hDEADBEEF, 1'b0);

    // Byte lane merge and extension
    access(1'b1, 32'h10, 32'h11223344, W, 1'b0, 32'hDEADBEEF, 1'b0);
    access(1'b1, 32'h13, 32'hFFFFFF80, B, 1'b0, 32'hDEADBEEF, 1'b0);
    access(1'b0, 32'h10, 32'h0, W, 1'b0, 32'h80223344, 1'b0);
    access(1'b0, 32'h13, 32'h0, B, 1'b1, 32'hFFFFFF80, 1'b0);
    access(1'b0, 32'h13, 32'h0, B, 1'b0, 32'h00000080, 1'b0);
    access(1'b0, 32'h11, 32'h0, B, 1'b1, 32'h00000033, 1'b0);

    // Half lane merge and extension
    access(1'b1, 32'h20, 32'h12345678, W, 1'b0, 32'h00000033, 1'b0);
    access(1'b1, 32'h22, 32'hAAAABEEF, H, 1'b0, 32'h00000033, 1'b0);
    access(1'b0, 32'h22, 32'h0, H, 1'b1, 32'hFFFFBEEF, 1'b0);
    access(1'b0, 32'h20, 32'h0, H, 1'b0, 32'h00005678, 1'b0);
    access(1'b0, 32'h20, 32'h0, W, 1'b0, 32'hBEEF5678, 1'b0);

    // Upper address bits ignored: 0x1030 aliases 0x30
    access(1'b1, 32'h1030, 32'hCAFEF00D, W, 1'b0, 32'hBEEF5678, 1'b0);
    access(1'b0, 32'h30, 32'h0, W, 1'b0, 32'hCAFEF00D, 1'b0);
    access(1'b1, 32'h40, 32'hA5A5A5A5, W, 1'b0, 32'hCAFEF00D, 1'b0);

    // Reset during WAIT of a store
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'h12345678; size = W; sign = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    check1("mid_busy_before_rst", busy2, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("mid_rst_busy", busy2, 1'b0);
    check1("mid_rst_ack", ack2, 1'b0);
    check32("mid_rst_rdata", rdata2, 32'h0);
    saw_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw_ack = saw_ack | ack2;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      saw_ack = saw_ack | ack2;
    end
    check1("mid_rst_no_ack", saw_ack, 1'b0);
    access(1'b0, 32'h40, 32'h0, W, 1'b0, 32'hA5A5A5A5, 1'b0);
    access(1'b0, 32'h30, 32'h0, W, 1'b0, 32'hCAFEF00D, 1'b0);

    // Misaligned word load
`ifdef DM_MISALIGN_TRAP_EN
    access(1'b0, 32'h41, 32'h0, W, 1'b0, 32'hCAFEF00D, 1'b1);
`else
    access(1'b0, 32'h41, 32'h0, W, 1'b0, 32'hA5A5A5A5, 1'b0);
`endif

    // Back-to-back on the zero-wait instance; addr is perturbed whenever it is busy
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h10; size = W; sign = 1'b0;
    n_ack = 0;
    prev_ack = 1'b0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (ack0) begin
        n_ack++;
        check32("b2b_rdata", rdata0, 32'h80223344);
        check1("b2b_no_consecutive_ack", prev_ack, 1'b0);
      end
      prev_ack = ack0;
      addr = busy0 ? 32'h20 : 32'h10;
    end
    req = 1'b0;
    check32("b2b_ack_count", 32'(n_ack), 32'd5);
    repeat (6) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
